// File: rtl/ex_stage_md_pkg.sv
// Shared types for the parametrised execute stage: ALU opcodes, mul/div FSM
// states and the EX/MEM control bundle.
package ex_pkg;

   typedef enum logic [3:0] {
      OP_AND   = 4'd0,
      OP_OR    = 4'd1,
      OP_ADD   = 4'd2,
      OP_SUB   = 4'd3,
      OP_SLT   = 4'd4,
      OP_NOR   = 4'd5,
      OP_XOR   = 4'd6,
      OP_SLL   = 4'd7,
      OP_MULTU = 4'd8,
      OP_DIVU  = 4'd9,
      OP_MFHI  = 4'd10,
      OP_MFLO  = 4'd11
   } alu_op_e;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   typedef struct packed {
      logic valid;
      logic reg_write;
      logic mem_read;
      logic mem_write;
   } exmem_ctrl_t;

   localparam exmem_ctrl_t CTRL_BUBBLE = '0;

   function automatic logic is_md_op(input logic [3:0] op);
      return (op == OP_MULTU) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/ex_stage_md_if.sv
// ID/EX -> EX -> EX/MEM signal bundle; slave is the execute stage, master drives it.
interface ex_stage_md_if #(
   parameter int XLEN = 32,
   parameter int NFWD = 2,
   parameter int RW   = 5
);
   localparam int SELW = $clog2(NFWD + 1);

   logic                 in_valid;
   logic                 flush;
   logic                 RegDst;
   logic                 ALUSrc;
   logic [3:0]           ALUOp;
   logic                 RegWrite_in;
   logic                 MemRead_in;
   logic                 MemWrite_in;
   logic [SELW-1:0]      fwdA;
   logic [SELW-1:0]      fwdB;
   logic [XLEN-1:0]      Data1;
   logic [XLEN-1:0]      Data2;
   logic [XLEN-1:0]      immediate;
   logic [NFWD*XLEN-1:0] fwdData;
   logic [RW-1:0]        Rt;
   logic [RW-1:0]        Rd;

   logic                 stall;
   logic                 out_valid;
   logic [XLEN-1:0]      ALUOut;
   logic [XLEN-1:0]      MemWriteData;
   logic [RW-1:0]        RegDest;
   logic                 RegWrite_out;
   logic                 MemRead_out;
   logic                 MemWrite_out;
   logic [XLEN-1:0]      hi;
   logic [XLEN-1:0]      lo;

   modport slave (
      input  in_valid, flush, RegDst, ALUSrc, ALUOp, RegWrite_in, MemRead_in, MemWrite_in,
             fwdA, fwdB, Data1, Data2, immediate, fwdData, Rt, Rd,
      output stall, out_valid, ALUOut, MemWriteData, RegDest, RegWrite_out, MemRead_out,
             MemWrite_out, hi, lo
   );

   modport master (
      output in_valid, flush, RegDst, ALUSrc, ALUOp, RegWrite_in, MemRead_in, MemWrite_in,
             fwdA, fwdB, Data1, Data2, immediate, fwdData, Rt, Rd,
      input  stall, out_valid, ALUOut, MemWriteData, RegDest, RegWrite_out, MemRead_out,
             MemWrite_out, hi, lo
   );

endinterface

// File: rtl/ex_stage_md_md_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle,
// owning the architectural HI/LO registers.
module md_unit
   import ex_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic            abort_i,
   input  logic            div_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            busy_o,
   output logic            last_o,
   output logic            done_o,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o
);
   localparam int CW = $clog2(XLEN);

   md_state_e       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            div_q, div_d;
   logic [XLEN-1:0] acc_q, acc_d, quo_q, quo_d, m_q, m_d, hi_q, hi_d, lo_q, lo_d;
   logic [XLEN:0]   mul_sum, rem_sh;
   logic [XLEN-1:0] rem_diff, acc_nx, quo_nx;
   logic            ge;

   // acc is the running high half (mul) or partial remainder (div); quo shifts
   // multiplier bits out and quotient bits in. B==0 divides fall out naturally.
   always_comb begin
      mul_sum  = {1'b0, acc_q} + (quo_q[0] ? {1'b0, m_q} : '0);
      rem_sh   = {acc_q, quo_q[XLEN-1]};
      ge       = rem_sh >= {1'b0, m_q};
      rem_diff = rem_sh[XLEN-1:0] - m_q;
      if (div_q) begin
         acc_nx = ge ? rem_diff : rem_sh[XLEN-1:0];
         quo_nx = {quo_q[XLEN-2:0], ge};
      end else begin
         acc_nx = mul_sum[XLEN:1];
         quo_nx = {mul_sum[0], quo_q[XLEN-1:1]};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      acc_d   = acc_q;
      quo_d   = quo_q;
      m_d     = m_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_o  = 1'b0;
      busy_o  = (state_q == MD_BUSY);
      last_o  = busy_o && (cnt_q == '0);
      case (state_q)
         MD_IDLE: begin
            if (start_i) begin
               state_d = MD_BUSY;
               cnt_d   = CW'(XLEN - 1);
               div_d   = div_i;
               acc_d   = '0;
               quo_d   = a_i;
               m_d     = b_i;
            end
         end
         MD_BUSY: begin
            if (abort_i) begin
               state_d = MD_IDLE;
               cnt_d   = '0;
            end else begin
               acc_d = acc_nx;
               quo_d = quo_nx;
               if (cnt_q == '0) begin
                  state_d = MD_IDLE;
                  hi_d    = acc_nx;
                  lo_d    = quo_nx;
                  done_o  = 1'b1;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         default: state_d = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
         div_q   <= 1'b0;
         acc_q   <= '0;
         quo_q   <= '0;
         m_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         acc_q   <= acc_d;
         quo_q   <= quo_d;
         m_q     <= m_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: rtl/ex_stage_md.sv
// Execute stage: N-source operand forwarding, ALU, iterative mul/div with stall
// handshake, and the EX/MEM pipeline register.
module ex_stage_md
   import ex_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NFWD = 2,
   parameter int RW   = 5
) (
   input logic          clk,
   input logic          rst_n,
   ex_stage_md_if.slave ex
);
   localparam int SELW = $clog2(NFWD + 1);
   localparam int SHW  = $clog2(XLEN);

   logic [XLEN-1:0] opa, opb_fwd, opb, alu_res, hi, lo;
   logic            md_start, md_busy, md_last, md_done;
   exmem_ctrl_t     ctrl_q, ctrl_d;
   logic [XLEN-1:0] alu_q, alu_d, wdata_q, wdata_d;
   logic [RW-1:0]   dest_q, dest_d;

   // Out-of-range selects fall back to register data.
   function automatic logic [XLEN-1:0] fwd_pick(input logic [SELW-1:0] sel,
                                                input logic [XLEN-1:0] rd,
                                                input logic [NFWD*XLEN-1:0] src);
      fwd_pick = rd;
      for (int k = 1; k <= NFWD; k++)
         if (int'(sel) == k) fwd_pick = src[(k-1)*XLEN +: XLEN];
   endfunction

   assign opa     = fwd_pick(ex.fwdA, ex.Data1, ex.fwdData);
   assign opb_fwd = fwd_pick(ex.fwdB, ex.Data2, ex.fwdData);
   assign opb     = ex.ALUSrc ? ex.immediate : opb_fwd;

   always_comb begin
      alu_res = '0;
      case (ex.ALUOp)
         OP_AND:  alu_res = opa & opb;
         OP_OR:   alu_res = opa | opb;
         OP_ADD:  alu_res = opa + opb;
         OP_SUB:  alu_res = opa - opb;
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(opa) < $signed(opb))};
         OP_NOR:  alu_res = ~(opa | opb);
         OP_XOR:  alu_res = opa ^ opb;
         OP_SLL:  alu_res = opa << opb[SHW-1:0];
         OP_MFHI: alu_res = hi;
         OP_MFLO: alu_res = lo;
         default: alu_res = '0;
      endcase
   end

   // Reset also masks issue so stall reads low while rst_n is held.
   assign md_start = rst_n && !md_busy && ex.in_valid && !ex.flush && is_md_op(ex.ALUOp);
   assign ex.stall = md_start || (md_busy && !md_last && !ex.flush);

   md_unit #(.XLEN(XLEN)) u_md (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (md_start),
      .abort_i (ex.flush),
      .div_i   (ex.ALUOp == OP_DIVU),
      .a_i     (opa),
      .b_i     (opb),
      .busy_o  (md_busy),
      .last_o  (md_last),
      .done_o  (md_done),
      .hi_o    (hi),
      .lo_o    (lo)
   );

   // Any cycle spent issuing or iterating becomes a bubble; completion is a
   // valid slot that writes nothing.
   always_comb begin
      ctrl_d  = CTRL_BUBBLE;
      alu_d   = alu_res;
      wdata_d = opb_fwd;
      dest_d  = ex.RegDst ? ex.Rd : ex.Rt;
      if (md_done) begin
         ctrl_d.valid = 1'b1;
         alu_d        = '0;
      end else if (ex.in_valid && !ex.flush && !md_busy && !md_start) begin
         ctrl_d = '{valid: 1'b1, reg_write: ex.RegWrite_in,
                    mem_read: ex.MemRead_in, mem_write: ex.MemWrite_in};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q  <= CTRL_BUBBLE;
         alu_q   <= '0;
         wdata_q <= '0;
         dest_q  <= '0;
      end else begin
         ctrl_q  <= ctrl_d;
         alu_q   <= alu_d;
         wdata_q <= wdata_d;
         dest_q  <= dest_d;
      end
   end

   assign ex.out_valid    = ctrl_q.valid;
   assign ex.RegWrite_out = ctrl_q.reg_write;
   assign ex.MemRead_out  = ctrl_q.mem_read;
   assign ex.MemWrite_out = ctrl_q.mem_write;
   assign ex.ALUOut       = alu_q;
   assign ex.MemWriteData = wdata_q;
   assign ex.RegDest      = dest_q;
   assign ex.hi           = hi;
   assign ex.lo           = lo;

endmodule
